// File: rtl/mem_issue_queue_if.sv
// Dispatch-side and issue-side handshake bundle for the memory issue queue.
// Latency: none, wires only.
// Backpressure: disp_ready throttles dispatch; rr_stall freezes the issue register.
// Ports: disp_* carry a dispatched memory op in; instr_* carry the issued op out.
interface mem_issue_queue_if #(
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 64
) ();
  logic                 disp_valid;
  logic                 disp_ready;
  logic [PREG_W-1:0]    disp_rs1_tag;
  logic                 disp_rs1_rdy;
  logic [PREG_W-1:0]    disp_rs2_tag;
  logic                 disp_rs2_rdy;
  logic [PREG_W-1:0]    disp_rd_tag;
  logic                 disp_rd_valid;
  logic                 disp_is_load;
  logic [PAYLOAD_W-1:0] disp_payload;

  logic                 rr_stall;
  logic                 instr_valid;
  logic [PREG_W-1:0]    instr_rs1_tag;
  logic [PREG_W-1:0]    instr_rs2_tag;
  logic [PREG_W-1:0]    instr_rd_tag;
  logic                 instr_rd_valid;
  logic                 instr_is_load;
  logic [PAYLOAD_W-1:0] instr_payload;

  // Queue side.
  modport slave (
    input  disp_valid, disp_rs1_tag, disp_rs1_rdy, disp_rs2_tag, disp_rs2_rdy,
           disp_rd_tag, disp_rd_valid, disp_is_load, disp_payload, rr_stall,
    output disp_ready, instr_valid, instr_rs1_tag, instr_rs2_tag, instr_rd_tag,
           instr_rd_valid, instr_is_load, instr_payload
  );

  // Dispatch / register-read side.
  modport master (
    output disp_valid, disp_rs1_tag, disp_rs1_rdy, disp_rs2_tag, disp_rs2_rdy,
           disp_rd_tag, disp_rd_valid, disp_is_load, disp_payload, rr_stall,
    input  disp_ready, instr_valid, instr_rs1_tag, instr_rs2_tag, instr_rd_tag,
           instr_rd_valid, instr_is_load, instr_payload
  );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue with tag wakeup and speculative load-dest broadcast.
// Latency: op pushed on edge N can be on instr_valid after edge N+1 (if at head, sources ready).
// Backpressure: disp_ready = not full (registered count); rr_stall holds instr_* and blocks pops.
// Ports: clk/rst_n/flush plain; io carries dispatch and issue buses; wake_* are
//        NUM_WAKE tag broadcasts; bcast_ld_spec_* is the load wakeup; occupancy = entry count.
module mem_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = 6,
  parameter int PAYLOAD_W = 64,
  parameter int NUM_WAKE  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  mem_issue_queue_if.slave           io,
  input  logic [NUM_WAKE-1:0]        wake_valid,
  input  logic [NUM_WAKE*PREG_W-1:0] wake_tag,
  output logic                       bcast_ld_spec_valid,
  output logic [PREG_W-1:0]          bcast_ld_spec_tag,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic [PREG_W-1:0]    rs1_tag_q [DEPTH];
  logic [PREG_W-1:0]    rs2_tag_q [DEPTH];
  logic [PREG_W-1:0]    rd_tag_q  [DEPTH];
  logic [DEPTH-1:0]     rd_vld_q;
  logic [DEPTH-1:0]     is_load_q;
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [DEPTH-1:0]     rs1_rdy_q, rs2_rdy_q;
  logic [DEPTH-1:0]     rs1_rdy_d, rs2_rdy_d;

  logic push, pop, issuable, issue_en;

  function automatic logic wake_hit(input logic [PREG_W-1:0]          tag,
                                    input logic [NUM_WAKE-1:0]        wv,
                                    input logic [NUM_WAKE*PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_WAKE; i++) begin
      if (wv[i] && (wt[i*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Ready bits with this cycle's wakeups folded in; the head check uses these so
  // a wakeup arriving in the issue cycle is not lost for a cycle.
  always_comb begin
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    for (int i = 0; i < DEPTH; i++) begin
      rs1_rdy_d[i] = rs1_rdy_q[i] | wake_hit(rs1_tag_q[i], wake_valid, wake_tag);
      rs2_rdy_d[i] = rs2_rdy_q[i] | wake_hit(rs2_tag_q[i], wake_valid, wake_tag);
    end
  end

  assign io.disp_ready = (count_q != CNT_W'(DEPTH));
  assign occupancy     = count_q;
  assign issuable      = (count_q != '0) && rs1_rdy_d[head_q] && rs2_rdy_d[head_q];
  assign issue_en      = !io.rr_stall && !flush;
  assign pop           = issue_en && issuable;
  assign push          = io.disp_valid && io.disp_ready && !flush;

  // Entry payload/tags need no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      rs1_tag_q[tail_q] <= io.disp_rs1_tag;
      rs2_tag_q[tail_q] <= io.disp_rs2_tag;
      rd_tag_q[tail_q]  <= io.disp_rd_tag;
      rd_vld_q[tail_q]  <= io.disp_rd_valid;
      is_load_q[tail_q] <= io.disp_is_load;
      payload_q[tail_q] <= io.disp_payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      rs1_rdy_q           <= '0;
      rs2_rdy_q           <= '0;
      io.instr_valid      <= 1'b0;
      io.instr_rs1_tag    <= '0;
      io.instr_rs2_tag    <= '0;
      io.instr_rd_tag     <= '0;
      io.instr_rd_valid   <= 1'b0;
      io.instr_is_load    <= 1'b0;
      io.instr_payload    <= '0;
      bcast_ld_spec_valid <= 1'b0;
      bcast_ld_spec_tag   <= '0;
    end else if (flush) begin
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      rs1_rdy_q           <= '0;
      rs2_rdy_q           <= '0;
      io.instr_valid      <= 1'b0;
      bcast_ld_spec_valid <= 1'b0;
    end else begin
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      // Push never targets a live entry (queue not full), so this override is safe.
      if (push) begin
        rs1_rdy_q[tail_q] <= io.disp_rs1_rdy | wake_hit(io.disp_rs1_tag, wake_valid, wake_tag);
        rs2_rdy_q[tail_q] <= io.disp_rs2_rdy | wake_hit(io.disp_rs2_tag, wake_valid, wake_tag);
        tail_q            <= tail_q + PTR_W'(1);
      end
      if (issue_en) begin
        io.instr_valid    <= issuable;
        io.instr_rs1_tag  <= rs1_tag_q[head_q];
        io.instr_rs2_tag  <= rs2_tag_q[head_q];
        io.instr_rd_tag   <= rd_tag_q[head_q];
        io.instr_rd_valid <= rd_vld_q[head_q];
        io.instr_is_load  <= is_load_q[head_q];
        io.instr_payload  <= payload_q[head_q];
      end
      if (pop) begin
        head_q            <= head_q + PTR_W'(1);
        bcast_ld_spec_tag <= rd_tag_q[head_q];
      end
      // One-shot: drops on the next edge even if rr_stall keeps instr_valid high.
      bcast_ld_spec_valid <= pop && is_load_q[head_q] && rd_vld_q[head_q];
      count_q             <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_mem_issue_queue.sv
module tb_mem_issue_queue;
  typedef struct {
    logic [5:0]  rs1, rs2, rd;
    logic        rdv, ld;
    logic [63:0] pl;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  wake_valid = '0;
  logic [17:0] wake_tag = '0;
  logic        bcast_ld_spec_valid;
  logic [5:0]  bcast_ld_spec_tag;
  logic [3:0]  occupancy;

  int tests = 0;
  int failed = 0;
  op_t sb[$];
  logic skip_q = 1'b1;

  mem_issue_queue_if #(.PREG_W(6), .PAYLOAD_W(64)) io ();

  mem_issue_queue #(.DEPTH(8), .PREG_W(6), .PAYLOAD_W(64), .NUM_WAKE(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .io(io),
    .wake_valid(wake_valid), .wake_tag(wake_tag),
    .bcast_ld_spec_valid(bcast_ld_spec_valid), .bcast_ld_spec_tag(bcast_ld_spec_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] r1, input logic r1r, input logic [5:0] r2,
                      input logic r2r, input logic [5:0] rd, input logic rdv,
                      input logic ld, input logic [63:0] pl);
    op_t o;
    io.disp_valid    = 1'b1;
    io.disp_rs1_tag  = r1;  io.disp_rs1_rdy  = r1r;
    io.disp_rs2_tag  = r2;  io.disp_rs2_rdy  = r2r;
    io.disp_rd_tag   = rd;  io.disp_rd_valid = rdv;
    io.disp_is_load  = ld;  io.disp_payload  = pl;
    if (io.disp_ready && !flush) begin
      o.rs1 = r1; o.rs2 = r2; o.rd = rd; o.rdv = rdv; o.ld = ld; o.pl = pl;
      sb.push_back(o);
    end
  endtask

  task automatic idle();
    io.disp_valid = 1'b0;
  endtask

  // Monitor: a freshly loaded issue register (previous edge not stalled/flushed)
  // must match the oldest outstanding dispatched op.
  always @(negedge clk) begin
    op_t e;
    if (rst_n && !skip_q && io.instr_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("issue_fields",
              {io.instr_rs1_tag, io.instr_rs2_tag, io.instr_rd_tag,
               io.instr_rd_valid, io.instr_is_load, io.instr_payload},
              {e.rs1, e.rs2, e.rd, e.rdv, e.ld, e.pl});
        check("issue_bcast_vld", bcast_ld_spec_valid, e.ld & e.rdv);
        if (e.ld & e.rdv) check("issue_bcast_tag", bcast_ld_spec_tag, e.rd);
      end
    end else if (rst_n) begin
      check("bcast_idle", bcast_ld_spec_valid, 1'b0);
    end
    skip_q = io.rr_stall | flush | !rst_n;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    io.disp_valid = 1'b0; io.rr_stall = 1'b0;
    io.disp_rs1_tag = '0; io.disp_rs1_rdy = 1'b0; io.disp_rs2_tag = '0; io.disp_rs2_rdy = 1'b0;
    io.disp_rd_tag = '0; io.disp_rd_valid = 1'b0; io.disp_is_load = 1'b0; io.disp_payload = '0;
    #2;
    check("rst_instr_valid", io.instr_valid, 1'b0);
    check("rst_bcast", {bcast_ld_spec_valid, bcast_ld_spec_tag}, 7'd0);
    check("rst_occ", occupancy, 4'd0);
    check("rst_disp_ready", io.disp_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Ready load: pushed on one edge, issued on the next.
    disp(6'd5, 1'b1, 6'd0, 1'b1, 6'd12, 1'b1, 1'b1, 64'h1111);
    tick(); idle();
    check("t1_occ_after_push", occupancy, 4'd1);
    check("t1_not_yet_valid", io.instr_valid, 1'b0);
    tick();
    check("t1_valid", io.instr_valid, 1'b1);
    check("t1_rd", io.instr_rd_tag, 6'd12);
    check("t1_bcast", {bcast_ld_spec_valid, bcast_ld_spec_tag}, {1'b1, 6'd12});
    check("t1_occ", occupancy, 4'd0);
    tick();
    check("t1_bcast_drop", bcast_ld_spec_valid, 1'b0);
    check("t1_valid_drop", io.instr_valid, 1'b0);

    // Store waiting on rs2=9, woken on port 1.
    disp(6'd3, 1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 1'b0, 64'h2222);
    tick(); idle();
    tick(); tick();
    check("t2_wait", io.instr_valid, 1'b0);
    wake_valid = 3'b010; wake_tag = {6'd0, 6'd9, 6'd0};
    tick();
    wake_valid = '0;
    check("t2_valid", io.instr_valid, 1'b1);
    check("t2_no_bcast", bcast_ld_spec_valid, 1'b0);
    tick();

    // In-order blocking: B ready but stuck behind A.
    disp(6'd7, 1'b0, 6'd1, 1'b1, 6'd20, 1'b1, 1'b0, 64'hA);
    tick();
    disp(6'd2, 1'b1, 6'd3, 1'b1, 6'd21, 1'b1, 1'b0, 64'hB);
    tick(); idle();
    tick(); tick();
    check("t3_blocked", io.instr_valid, 1'b0);
    check("t3_occ", occupancy, 4'd2);
    wake_valid = 3'b001; wake_tag = {6'd0, 6'd0, 6'd7};
    tick();
    wake_valid = '0;
    check("t3_a_first", {io.instr_valid, io.instr_rd_tag}, {1'b1, 6'd20});
    tick();
    check("t3_b_second", {io.instr_valid, io.instr_rd_tag}, {1'b1, 6'd21});
    tick();
    check("t3_drained", occupancy, 4'd0);

    // Fill under stall, reject 9th, then push+pop at count 5.
    io.rr_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      disp(6'(20 + i), 1'b0, 6'd0, 1'b1, 6'(30 + i), 1'b1, 1'b0, 64'(16'h4000 + i));
      tick();
    end
    idle();
    check("t4_full_occ", occupancy, 4'd8);
    check("t4_full_ready", io.disp_ready, 1'b0);
    disp(6'd1, 1'b1, 6'd1, 1'b1, 6'd45, 1'b1, 1'b0, 64'hDEAD);
    tick(); idle();
    check("t4_ninth_ignored", occupancy, 4'd8);
    wake_valid = 3'b111; wake_tag = {6'd22, 6'd21, 6'd20};
    tick();
    wake_tag = {6'd25, 6'd24, 6'd23};
    tick();
    wake_valid = '0;
    io.rr_stall = 1'b0;
    tick(); tick(); tick();
    check("t4_occ5", occupancy, 4'd5);
    disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd44, 1'b1, 1'b1, 64'h5555);
    tick(); idle();
    check("t4_push_pop_occ", occupancy, 4'd5);
    wake_valid = 3'b011; wake_tag = {6'd0, 6'd27, 6'd26};
    tick();
    wake_valid = '0;
    for (int i = 0; i < 20; i++) begin
      if (occupancy == 4'd0) break;
      tick();
    end
    check("t4_drain", occupancy, 4'd0);
    tick();

    // Load issue held by rr_stall for 3 extra cycles.
    disp(6'd4, 1'b1, 6'd6, 1'b1, 6'd33, 1'b1, 1'b1, 64'hCAFE);
    tick(); idle();
    tick();
    io.rr_stall = 1'b1;
    check("t5_c0", {io.instr_valid, io.instr_rd_tag, io.instr_payload}, {1'b1, 6'd33, 64'hCAFE});
    check("t5_c0_bcast", {bcast_ld_spec_valid, bcast_ld_spec_tag}, {1'b1, 6'd33});
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t5_hold", {io.instr_valid, io.instr_rd_tag, io.instr_payload}, {1'b1, 6'd33, 64'hCAFE});
      check("t5_bcast_off", bcast_ld_spec_valid, 1'b0);
    end
    io.rr_stall = 1'b0;
    tick();
    check("t5_release", io.instr_valid, 1'b0);

    // Flush with occupancy 4 and instr_valid held; concurrent dispatch dropped.
    disp(6'd1, 1'b1, 6'd1, 1'b1, 6'd60, 1'b1, 1'b0, 64'h60);
    tick();
    disp(6'd50, 1'b0, 6'd1, 1'b1, 6'd61, 1'b1, 1'b0, 64'h61);
    tick();
    io.rr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      disp(6'd50, 1'b0, 6'd1, 1'b1, 6'(62 + i), 1'b1, 1'b0, 64'(8'h62 + i));
      tick();
    end
    idle();
    check("t6_pre_occ", occupancy, 4'd4);
    check("t6_pre_valid", io.instr_valid, 1'b1);
    flush = 1'b1;
    disp(6'd1, 1'b1, 6'd1, 1'b1, 6'd9, 1'b1, 1'b1, 64'h77);
    tick();
    flush = 1'b0; idle(); io.rr_stall = 1'b0;
    sb.delete();
    check("t6_occ", occupancy, 4'd0);
    check("t6_valid", io.instr_valid, 1'b0);
    check("t6_ready", io.disp_ready, 1'b1);
    check("t6_bcast", bcast_ld_spec_valid, 1'b0);
    tick(); tick(); tick();
    check("t6_op_lost", {io.instr_valid, occupancy}, 5'd0);

    // Asynchronous reset mid-cycle.
    disp(6'd1, 1'b1, 6'd1, 1'b1, 6'd13, 1'b1, 1'b1, 64'h1313);
    tick();
    disp(6'd51, 1'b0, 6'd1, 1'b1, 6'd14, 1'b1, 1'b0, 64'h1414);
    tick(); idle();
    check("t7_pre", {io.instr_valid, bcast_ld_spec_valid, occupancy}, {1'b1, 1'b1, 4'd1});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_async", {io.instr_valid, io.instr_rd_tag, bcast_ld_spec_valid, bcast_ld_spec_tag, occupancy},
          {1'b0, 6'd0, 1'b0, 6'd0, 4'd0});
    check("t7_ready", io.disp_ready, 1'b1);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("end_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
